// File: rtl/cfg_reg_arbiter_if.sv
// Requester A/B byte ports plus the load-bus outputs of the config-register arbiter.
interface cfg_reg_arbiter_if #(
   parameter int unsigned NUM_REGS = 4,
   parameter int unsigned ADDR_W   = 2
);
   logic              a_req;
   logic [ADDR_W-1:0] a_addr;
   logic              a_hi;
   logic [7:0]        a_data;
   logic              a_ack;

   logic              b_req;
   logic [ADDR_W-1:0] b_addr;
   logic              b_hi;
   logic [7:0]        b_data;
   logic              b_ack;

   logic [15:0]         D;
   logic [NUM_REGS-1:0] load;
   logic                err;
   logic                busy;

   // Arbiter side
   modport slave (
      input  a_req, a_addr, a_hi, a_data,
      input  b_req, b_addr, b_hi, b_data,
      output a_ack, b_ack, D, load, err, busy
   );

   // Requester / register-bank side
   modport master (
      output a_req, a_addr, a_hi, a_data,
      output b_req, b_addr, b_hi, b_data,
      input  a_ack, b_ack, D, load, err, busy
   );
endinterface

// File: rtl/cfg_reg_arbiter.sv
// Round-robin arbiter sharing NUM_REGS 16-bit load registers between two byte-wide
// requesters. Low bytes are staged per requester; a high-byte write commits the word.
module cfg_reg_arbiter #(
   parameter int unsigned NUM_REGS = 4,
   parameter int unsigned ADDR_W   = 2
) (
   input logic              clk,
   input logic              reset,
   cfg_reg_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACK, COMMIT} state_t;

   state_t              state;
   logic                last_b;     // 1: B was granted last
   logic                w_b;        // winner of the current transfer (1 = B)
   logic [ADDR_W-1:0]   w_addr;
   logic                w_hi;
   logic [7:0]          w_data;
   logic [7:0]          lo_stage [2];
   logic [1:0]          lo_valid;

   logic                grant_b;
   logic                addr_bad;
   logic [NUM_REGS-1:0] addr_dec;

   // Round-robin choice: on a tie, B wins only if A was granted last
   always_comb grant_b = bus.b_req && (!bus.a_req || !last_b);

   // Captured address outside the populated register range
   always_comb addr_bad = (32'(w_addr) >= NUM_REGS);

   // One-hot decode of the captured address for the load strobe
   always_comb begin
      addr_dec = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (32'(w_addr) == i) addr_dec[i] = 1'b1;
      end
   end

   // Busy whenever the FSM is outside IDLE
   always_comb bus.busy = (state != IDLE);

   // Arbitration FSM with registered ack/err/load/D outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last_b      <= 1'b1;
         w_b         <= 1'b0;
         w_addr      <= '0;
         w_hi        <= 1'b0;
         w_data      <= '0;
         lo_stage[0] <= '0;
         lo_stage[1] <= '0;
         lo_valid    <= '0;
         bus.a_ack   <= 1'b0;
         bus.b_ack   <= 1'b0;
         bus.D       <= '0;
         bus.load    <= '0;
         bus.err     <= 1'b0;
      end else begin
         bus.a_ack <= 1'b0;
         bus.b_ack <= 1'b0;
         bus.load  <= '0;
         bus.err   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.a_req || bus.b_req) begin
                  w_b       <= grant_b;
                  last_b    <= grant_b;
                  w_addr    <= grant_b ? bus.b_addr : bus.a_addr;
                  w_hi      <= grant_b ? bus.b_hi   : bus.a_hi;
                  w_data    <= grant_b ? bus.b_data : bus.a_data;
                  bus.a_ack <= !grant_b;
                  bus.b_ack <= grant_b;
                  state     <= ACK;
               end
            end
            ACK: begin
               if (addr_bad) begin
                  bus.err <= 1'b1;
                  state   <= IDLE;
               end else if (!w_hi) begin
                  lo_stage[w_b] <= w_data;
                  lo_valid[w_b] <= 1'b1;
                  state         <= IDLE;
               end else if (lo_valid[w_b]) begin
                  // D and load register on the same edge, so the strobe is high
                  // exactly during COMMIT and D is already stable under it
                  bus.D    <= {w_data, lo_stage[w_b]};
                  bus.load <= addr_dec;
                  state    <= COMMIT;
               end else begin
                  bus.err <= 1'b1;
                  state   <= IDLE;
               end
            end
            COMMIT: begin
               lo_valid[w_b] <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Scoreboard bench for cfg_reg_arbiter: stimulus queues expected ack/load/err events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_cfg_reg_arbiter;

   localparam int unsigned NR = 3;
   localparam int unsigned AW = 2;

   localparam int EV_AA = 0;   // a_ack
   localparam int EV_AB = 1;   // b_ack
   localparam int EV_LD = 2;   // load strobe with D
   localparam int EV_ER = 3;   // err pulse

   typedef struct {
      int          kind;
      logic [2:0]  ld;
      logic [15:0] d;
   } ev_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   cfg_reg_arbiter_if #(.NUM_REGS(NR), .ADDR_W(AW)) bus ();

   cfg_reg_arbiter #(.NUM_REGS(NR), .ADDR_W(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   ev_t         expq[$];
   int          ncheck = 0;
   int          nfail  = 0;
   int          cyc    = 0;
   int          prev_ld = -1;
   int          idle_cnt = 0;
   bit          t6_on = 1'b0;
   logic [15:0] last_d = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncheck++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_ev(input int kind, input logic [2:0] ld, input logic [15:0] d);
      ev_t e;
      e.kind = kind;
      e.ld   = ld;
      e.d    = d;
      expq.push_back(e);
   endtask

   task automatic see(input int kind, input logic [2:0] ld, input logic [15:0] d);
      ev_t e;
      if (expq.size() == 0) begin
         ncheck++;
         nfail++;
         $display("FAIL unexpected_event: got kind %0d load 0x%0h D 0x%0h, expected none (cycle %0d)",
                  kind, ld, d, cyc);
      end else begin
         e = expq.pop_front();
         check("event_kind", 32'(kind), 32'(e.kind));
         if (kind == EV_LD && e.kind == EV_LD) begin
            check("load_vec", 32'(ld), 32'(e.ld));
            check("load_D", 32'(d), 32'(e.d));
            last_d = e.d;
            if (t6_on) begin
               if (prev_ld >= 0) begin
                  // IDLE, ACK(lo), IDLE, ACK(hi), COMMIT between strobes
                  check("load_spacing", 32'(cyc - prev_ld), 32'd5);
                  check("idle_cycles", 32'(idle_cnt), 32'd2);
               end
               prev_ld  = cyc;
               idle_cnt = 0;
            end
         end
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         last_d = '0;
      end else begin
         if (bus.a_ack) see(EV_AA, '0, '0);
         if (bus.b_ack) see(EV_AB, '0, '0);
         if (bus.load != '0) begin
            check("load_onehot", 32'($onehot(bus.load)), 32'd1);
            check("err_load_excl", 32'(bus.err), 32'd0);
            see(EV_LD, bus.load, bus.D);
         end else begin
            check("d_hold", 32'(bus.D), 32'(last_d));
         end
         if (bus.err) see(EV_ER, '0, '0);
         if (!bus.busy) idle_cnt++;
      end
   end

   task automatic drive_a(input logic [1:0] addr, input logic hi, input logic [7:0] data, input bit keep);
      int n = 0;
      bus.a_req  = 1'b1;
      bus.a_addr = addr;
      bus.a_hi   = hi;
      bus.a_data = data;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.a_ack && n < 30);
      check("a_ack_wait", 32'(bus.a_ack), 32'd1);
      if (!keep) bus.a_req = 1'b0;
   endtask

   task automatic drive_b(input logic [1:0] addr, input logic hi, input logic [7:0] data, input bit keep);
      int n = 0;
      bus.b_req  = 1'b1;
      bus.b_addr = addr;
      bus.b_hi   = hi;
      bus.b_data = data;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!bus.b_ack && n < 30);
      check("b_ack_wait", 32'(bus.b_ack), 32'd1);
      if (!keep) bus.b_req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_a_ack"}, 32'(bus.a_ack), 32'd0);
      check({tag, "_b_ack"}, 32'(bus.b_ack), 32'd0);
      check({tag, "_load"},  32'(bus.load),  32'd0);
      check({tag, "_err"},   32'(bus.err),   32'd0);
      check({tag, "_D"},     32'(bus.D),     32'd0);
      check({tag, "_busy"},  32'(bus.busy),  32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      bus.a_req = 1'b0; bus.a_addr = '0; bus.a_hi = 1'b0; bus.a_data = '0;
      bus.b_req = 1'b0; bus.b_addr = '0; bus.b_hi = 1'b0; bus.b_data = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_quiet("reset");
      reset = 1'b0;
      idle(2);

      // 1: A writes 0x1234 to register 1
      expect_ev(EV_AA, '0, '0);
      expect_ev(EV_AA, '0, '0);
      expect_ev(EV_LD, 3'b010, 16'h1234);
      drive_a(2'd1, 1'b0, 8'h34, 1'b0);
      drive_a(2'd1, 1'b1, 8'h12, 1'b0);
      idle(4);

      // 2: simultaneous requests from reset, held contention
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      expect_ev(EV_AA, '0, '0);
      expect_ev(EV_AB, '0, '0);
      expect_ev(EV_AA, '0, '0);
      expect_ev(EV_LD, 3'b001, 16'hA001);
      expect_ev(EV_AB, '0, '0);
      expect_ev(EV_LD, 3'b010, 16'hB002);
      fork
         begin
            drive_a(2'd0, 1'b0, 8'h01, 1'b1);
            drive_a(2'd0, 1'b1, 8'hA0, 1'b0);
         end
         begin
            drive_b(2'd1, 1'b0, 8'h02, 1'b1);
            drive_b(2'd1, 1'b1, 8'hB0, 1'b0);
         end
      join
      idle(4);

      // 3: interleaved byte pairs keep separate staging
      expect_ev(EV_AA, '0, '0);
      expect_ev(EV_AB, '0, '0);
      expect_ev(EV_AB, '0, '0);
      expect_ev(EV_LD, 3'b001, 16'h2211);
      expect_ev(EV_AA, '0, '0);
      expect_ev(EV_LD, 3'b100, 16'hABCD);
      drive_a(2'd2, 1'b0, 8'hCD, 1'b0);
      drive_b(2'd0, 1'b0, 8'h11, 1'b0);
      drive_b(2'd0, 1'b1, 8'h22, 1'b0);
      drive_a(2'd2, 1'b1, 8'hAB, 1'b0);
      idle(4);

      // 4: high byte with nothing staged, then out-of-range address
      expect_ev(EV_AB, '0, '0);
      expect_ev(EV_ER, '0, '0);
      drive_b(2'd1, 1'b1, 8'h55, 1'b0);
      expect_ev(EV_AA, '0, '0);
      expect_ev(EV_ER, '0, '0);
      expect_ev(EV_AA, '0, '0);
      expect_ev(EV_ER, '0, '0);
      drive_a(2'd3, 1'b0, 8'h77, 1'b0);
      drive_a(2'd3, 1'b1, 8'h88, 1'b0);
      idle(4);

      // 5: reset during ACK of a commit discards the staged low byte
      expect_ev(EV_AA, '0, '0);
      drive_a(2'd1, 1'b0, 8'h99, 1'b0);
      drive_a(2'd1, 1'b1, 8'h66, 1'b0);
      reset = 1'b1;
      idle(1);
      check_quiet("midreset");
      reset = 1'b0;
      idle(1);
      expect_ev(EV_AA, '0, '0);
      expect_ev(EV_ER, '0, '0);
      drive_a(2'd1, 1'b1, 8'h66, 1'b0);
      idle(4);

      // 6: back-to-back commits with req held
      t6_on = 1'b1;
      expect_ev(EV_AA, '0, '0);
      expect_ev(EV_AA, '0, '0);
      expect_ev(EV_LD, 3'b001, 16'h2211);
      expect_ev(EV_AA, '0, '0);
      expect_ev(EV_AA, '0, '0);
      expect_ev(EV_LD, 3'b001, 16'h4433);
      expect_ev(EV_AA, '0, '0);
      expect_ev(EV_AA, '0, '0);
      expect_ev(EV_LD, 3'b001, 16'h6655);
      drive_a(2'd0, 1'b0, 8'h11, 1'b1);
      drive_a(2'd0, 1'b1, 8'h22, 1'b1);
      drive_a(2'd0, 1'b0, 8'h33, 1'b1);
      drive_a(2'd0, 1'b1, 8'h44, 1'b1);
      drive_a(2'd0, 1'b0, 8'h55, 1'b1);
      drive_a(2'd0, 1'b1, 8'h66, 1'b0);
      idle(10);
      t6_on = 1'b0;

      check("queue_drained", 32'(expq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
      $finish;
   end

endmodule
